// File: rtl/axil_arb_pkg.sv
// Shared types for the 2:1 AXI4-Lite arbiter: FSM encodings, response codes, grant index.
package axil_arb_pkg;

    typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // 0 = s0, 1 = s1
    typedef logic gnt_idx_t;

endpackage

// File: rtl/axil_rr_arb2.sv
// Two-way round-robin picker: with both requesting, the side not served last wins.
module axil_rr_arb2
    import axil_arb_pkg::*;
(
    input  logic [1:0] req,
    input  gnt_idx_t   last,
    input  logic       enable,
    output gnt_idx_t   gnt,
    output logic       gnt_valid
);

    always_comb begin
        gnt_valid = enable & (|req);
        if (req == 2'b11) begin
            gnt = ~last;
        end else begin
            gnt = req[1];
        end
    end

endmodule

// File: rtl/axil_arbiter_2to1.sv
// 2:1 AXI4-Lite arbiter, independent round-robin write and read paths, one outstanding each.
// state  | meaning
// W_IDLE | no write grant; pick a winner on sN_awvalid
// W_XFER | forward winner's aw and w until both handshakes seen
// W_RESP | route b channel to winner until b handshake
// R_IDLE | no read grant; pick a winner on sN_arvalid
// R_ADDR | forward winner's ar until handshake
// R_DATA | route r channel to winner until handshake
module axil_arbiter_2to1
    import axil_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    axi_aclk,
    input  logic                    axi_areset,
    input  logic [ADDR_WIDTH-1:0]   s0_axi_awaddr,
    input  logic                    s0_axi_awvalid,
    output logic                    s0_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s0_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s0_axi_wstrb,
    input  logic                    s0_axi_wvalid,
    output logic                    s0_axi_wready,
    output logic [1:0]              s0_axi_bresp,
    output logic                    s0_axi_bvalid,
    input  logic                    s0_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s0_axi_araddr,
    input  logic                    s0_axi_arvalid,
    output logic                    s0_axi_arready,
    output logic [DATA_WIDTH-1:0]   s0_axi_rdata,
    output logic [1:0]              s0_axi_rresp,
    output logic                    s0_axi_rvalid,
    input  logic                    s0_axi_rready,
    input  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr,
    input  logic                    s1_axi_awvalid,
    output logic                    s1_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s1_axi_wstrb,
    input  logic                    s1_axi_wvalid,
    output logic                    s1_axi_wready,
    output logic [1:0]              s1_axi_bresp,
    output logic                    s1_axi_bvalid,
    input  logic                    s1_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s1_axi_araddr,
    input  logic                    s1_axi_arvalid,
    output logic                    s1_axi_arready,
    output logic [DATA_WIDTH-1:0]   s1_axi_rdata,
    output logic [1:0]              s1_axi_rresp,
    output logic                    s1_axi_rvalid,
    input  logic                    s1_axi_rready,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    wr_state_t w_state;
    rd_state_t r_state;
    gnt_idx_t  wgnt, last_wgnt, w_pick;
    gnt_idx_t  rgnt, last_rgnt, r_pick;
    logic      w_pick_valid, r_pick_valid;
    logic      aw_done, w_done;
    logic      aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic      in_wxfer, in_wresp, in_raddr, in_rdata;
    logic      sel_awvalid, sel_wvalid, sel_bready, sel_arvalid, sel_rready;

    axil_rr_arb2 u_warb (
        .req       ({s1_axi_awvalid, s0_axi_awvalid}),
        .last      (last_wgnt),
        .enable    (w_state == W_IDLE),
        .gnt       (w_pick),
        .gnt_valid (w_pick_valid)
    );

    axil_rr_arb2 u_rarb (
        .req       ({s1_axi_arvalid, s0_axi_arvalid}),
        .last      (last_rgnt),
        .enable    (r_state == R_IDLE),
        .gnt       (r_pick),
        .gnt_valid (r_pick_valid)
    );

    assign in_wxfer = (w_state == W_XFER);
    assign in_wresp = (w_state == W_RESP);
    assign in_raddr = (r_state == R_ADDR);
    assign in_rdata = (r_state == R_DATA);

    assign sel_awvalid = wgnt ? s1_axi_awvalid : s0_axi_awvalid;
    assign sel_wvalid  = wgnt ? s1_axi_wvalid  : s0_axi_wvalid;
    assign sel_bready  = wgnt ? s1_axi_bready  : s0_axi_bready;
    assign sel_arvalid = rgnt ? s1_axi_arvalid : s0_axi_arvalid;
    assign sel_rready  = rgnt ? s1_axi_rready  : s0_axi_rready;

    // A channel whose handshake already happened is masked so it is never presented twice.
    assign m_axi_awaddr  = wgnt ? s1_axi_awaddr : s0_axi_awaddr;
    assign m_axi_awvalid = in_wxfer & sel_awvalid & ~aw_done;
    assign m_axi_wdata   = wgnt ? s1_axi_wdata : s0_axi_wdata;
    assign m_axi_wstrb   = wgnt ? s1_axi_wstrb : s0_axi_wstrb;
    assign m_axi_wvalid  = in_wxfer & sel_wvalid & ~w_done;
    assign m_axi_bready  = in_wresp & sel_bready;
    assign m_axi_araddr  = rgnt ? s1_axi_araddr : s0_axi_araddr;
    assign m_axi_arvalid = in_raddr & sel_arvalid;
    assign m_axi_rready  = in_rdata & sel_rready;

    assign aw_hs = m_axi_awvalid & m_axi_awready;
    assign w_hs  = m_axi_wvalid & m_axi_wready;
    assign b_hs  = m_axi_bready & m_axi_bvalid;
    assign ar_hs = m_axi_arvalid & m_axi_arready;
    assign r_hs  = m_axi_rready & m_axi_rvalid;

    assign s0_axi_awready = in_wxfer & ~wgnt & m_axi_awready & ~aw_done;
    assign s1_axi_awready = in_wxfer &  wgnt & m_axi_awready & ~aw_done;
    assign s0_axi_wready  = in_wxfer & ~wgnt & m_axi_wready & ~w_done;
    assign s1_axi_wready  = in_wxfer &  wgnt & m_axi_wready & ~w_done;
    assign s0_axi_bvalid  = in_wresp & ~wgnt & m_axi_bvalid;
    assign s1_axi_bvalid  = in_wresp &  wgnt & m_axi_bvalid;
    assign s0_axi_bresp   = (in_wresp && !wgnt) ? m_axi_bresp : RESP_OKAY;
    assign s1_axi_bresp   = (in_wresp &&  wgnt) ? m_axi_bresp : RESP_OKAY;

    assign s0_axi_arready = in_raddr & ~rgnt & m_axi_arready;
    assign s1_axi_arready = in_raddr &  rgnt & m_axi_arready;
    assign s0_axi_rvalid  = in_rdata & ~rgnt & m_axi_rvalid;
    assign s1_axi_rvalid  = in_rdata &  rgnt & m_axi_rvalid;
    assign s0_axi_rdata   = (in_rdata && !rgnt) ? m_axi_rdata : '0;
    assign s1_axi_rdata   = (in_rdata &&  rgnt) ? m_axi_rdata : '0;
    assign s0_axi_rresp   = (in_rdata && !rgnt) ? m_axi_rresp : RESP_OKAY;
    assign s1_axi_rresp   = (in_rdata &&  rgnt) ? m_axi_rresp : RESP_OKAY;

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            w_state   <= W_IDLE;
            wgnt      <= 1'b0;
            last_wgnt <= 1'b1;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (w_pick_valid) begin
                        wgnt      <= w_pick;
                        last_wgnt <= w_pick;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                        w_state   <= W_XFER;
                    end
                end
                W_XFER: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                    if ((aw_done | aw_hs) && (w_done | w_hs)) w_state <= W_RESP;
                end
                W_RESP: begin
                    if (b_hs) w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            r_state   <= R_IDLE;
            rgnt      <= 1'b0;
            last_rgnt <= 1'b1;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (r_pick_valid) begin
                        rgnt      <= r_pick;
                        last_rgnt <= r_pick;
                        r_state   <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (ar_hs) r_state <= R_DATA;
                end
                R_DATA: begin
                    if (r_hs) r_state <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule
